// File: rtl/stream_checker_64.sv
// stream_checker_64: AXI4-Stream sink that checks a 64-bit counter pattern, tlast framing and tkeep
module stream_checker_64 #(
    parameter int          DATA_WIDTH = 64,
    parameter int          KEEP_WIDTH = 8,
    parameter int          PKT_WIDTH  = 11,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                  user_clk,
    input  logic                  dma_rstn,
    input  logic                  chk_ena,
    input  logic                  throttle_ena,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [31:0]           word_cnt,
    output logic [31:0]           pkt_cnt,
    output logic [15:0]           err_cnt,
    output logic [31:0]           first_err_word,
    output logic [3:0]            err_flags,
    output logic                  synced
);
    typedef enum logic [1:0] {IDLE, SYNC, RUN} state_t;

    state_t      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic        tready_q, tready_d;
    logic [31:0] exp_q, exp_d;
    logic [31:0] word_q, word_d;
    logic [31:0] pkt_q, pkt_d;
    logic [31:0] first_q, first_d;
    logic [15:0] err_q, err_d;
    logic [3:0]  flags_q, flags_d;
    logic        acc, pat_ok, data_err, tlast_exp;
    logic [31:0] cnt;
    logic [3:0]  beat_err;

    // Decode the beat and classify its errors; framing uses the beat's own count until synced
    always_comb begin
        cnt       = s_axis_tdata[32:1];
        acc       = s_axis_tvalid && tready_q;
        pat_ok    = !s_axis_tdata[0] && s_axis_tdata[33] && (s_axis_tdata[63:34] == cnt[29:0]);
        data_err  = !pat_ok || (state_q == RUN && cnt != exp_q);
        tlast_exp = (state_q == RUN) ? &exp_q[PKT_WIDTH-1:0] : &cnt[PKT_WIDTH-1:0];
        beat_err  = {s_axis_tkeep != {KEEP_WIDTH{1'b1}}, s_axis_tlast && !tlast_exp,
                     tlast_exp && !s_axis_tlast, data_err};
    end

    // Next-state, statistics update and registered tready (never a function of tvalid)
    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        word_d  = word_q;
        pkt_d   = pkt_q;
        first_d = first_q;
        err_d   = err_q;
        flags_d = flags_q;
        lfsr_d  = (state_q == IDLE) ? lfsr_q
                : {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        case (state_q)
            IDLE: begin
                if (chk_ena) begin
                    state_d = SYNC;
                    word_d  = '0;
                    pkt_d   = '0;
                    first_d = '0;
                    err_d   = '0;
                    flags_d = '0;
                end
            end
            default: begin
                if (acc) begin
                    state_d = RUN;
                    exp_d   = (state_q != RUN || data_err) ? cnt + 32'd1 : exp_q + 32'd1;
                    word_d  = word_q + 32'd1;
                    pkt_d   = pkt_q + {31'd0, s_axis_tlast};
                    if (|beat_err) begin
                        flags_d = flags_q | beat_err;
                        err_d   = (&err_q) ? err_q : err_q + 16'd1;
                        if (err_q == 16'd0) first_d = word_q;
                    end
                end
                if (!chk_ena) state_d = IDLE;
            end
        endcase
        tready_d = (state_d != IDLE) && (!throttle_ena || lfsr_d[1:0] != 2'b00);
    end

    // State and statistics registers
    always_ff @(posedge user_clk or negedge dma_rstn) begin
        if (!dma_rstn) begin
            state_q  <= IDLE;
            lfsr_q   <= LFSR_SEED;
            tready_q <= 1'b0;
            exp_q    <= '0;
            word_q   <= '0;
            pkt_q    <= '0;
            first_q  <= '0;
            err_q    <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            tready_q <= tready_d;
            exp_q    <= exp_d;
            word_q   <= word_d;
            pkt_q    <= pkt_d;
            first_q  <= first_d;
            err_q    <= err_d;
            flags_q  <= flags_d;
        end
    end

    assign s_axis_tready  = tready_q;
    assign word_cnt       = word_q;
    assign pkt_cnt        = pkt_q;
    assign err_cnt        = err_q;
    assign first_err_word = first_q;
    assign err_flags      = flags_q;
    assign synced         = (state_q == RUN);
endmodule

// File: tb/tb_stream_checker_64.sv
// tb_stream_checker_64: randomized and directed bench for stream_checker_64 against a counter-stream model
module tb_stream_checker_64;
    logic        user_clk = 1'b0;
    logic        dma_rstn = 1'b0;
    logic        chk_ena = 1'b0;
    logic        throttle_ena = 1'b0;
    logic [63:0] s_axis_tdata = '0;
    logic [7:0]  s_axis_tkeep = 8'hFF;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        s_axis_tlast = 1'b0;
    logic [31:0] word_cnt, pkt_cnt, first_err_word;
    logic [15:0] err_cnt;
    logic [3:0]  err_flags;
    logic        synced;

    stream_checker_64 dut (
        .user_clk(user_clk), .dma_rstn(dma_rstn), .chk_ena(chk_ena), .throttle_ena(throttle_ena),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast), .word_cnt(word_cnt),
        .pkt_cnt(pkt_cnt), .err_cnt(err_cnt), .first_err_word(first_err_word),
        .err_flags(err_flags), .synced(synced)
    );

    always #5 user_clk = ~user_clk;

    int total = 0;
    int bad = 0;
    int stall_cyc = 0;
    int run_cyc = 0;

    // Reference model: statistics derived from the sequence of accepted beats
    logic [31:0] m_words, m_pkts, m_first, m_exp;
    logic [15:0] m_errs;
    logic [3:0]  m_flags;
    bit          m_synced;

    function automatic logic [63:0] mk(input logic [31:0] c);
        return {c[29:0], 1'b1, c, 1'b0};
    endfunction

    function automatic bit is_last(input logic [31:0] c);
        return c[10:0] == 11'h7FF;
    endfunction

    function automatic void model_clear();
        m_words = 0; m_pkts = 0; m_first = 0; m_errs = 0; m_flags = 0; m_synced = 0; m_exp = 0;
    endfunction

    function automatic void model_acc(input logic [63:0] d, input logic l, input logic [7:0] k);
        logic [31:0] c;
        bit ok, derr, want_last;
        logic [3:0] e;
        c = d[32:1];
        ok = (d[0] == 1'b0) && d[33] && (d[63:34] == c[29:0]);
        if (!m_synced) begin
            derr = !ok;
            want_last = is_last(c);
            m_exp = c + 1;
            m_synced = 1;
        end else begin
            derr = !ok || (c != m_exp);
            want_last = is_last(m_exp);
            m_exp = derr ? c + 1 : m_exp + 1;
        end
        e = {k != 8'hFF, l && !want_last, want_last && !l, derr};
        if (e != 0) begin
            if (m_errs == 0) m_first = m_words;
            if (m_errs != 16'hFFFF) m_errs = m_errs + 1;
            m_flags = m_flags | e;
        end
        m_words = m_words + 1;
        if (l) m_pkts = m_pkts + 1;
    endfunction

    task automatic send_beat(input logic [63:0] d, input logic l, input logic [7:0] k);
        bit ok = 0;
        int n = 0;
        s_axis_tdata = d; s_axis_tlast = l; s_axis_tkeep = k; s_axis_tvalid = 1'b1;
        while (!ok && n < 64) begin
            @(negedge user_clk);
            ok = s_axis_tready;
            if (synced) begin
                run_cyc++;
                if (!ok) stall_cyc++;
            end
            @(posedge user_clk); #1;
            n++;
        end
        if (ok) model_acc(d, l, k);
        else begin
            total++; bad++;
            $display("FAIL send_timeout tready stayed low for %0d cycles, needed 1", n);
        end
    endtask

    task automatic idle(input int n);
        s_axis_tvalid = 1'b0;
        repeat (n) begin @(posedge user_clk); #1; end
    endtask

    task automatic restart();
        s_axis_tvalid = 1'b0; chk_ena = 1'b0;
        repeat (2) begin @(posedge user_clk); #1; end
        chk_ena = 1'b1;
        model_clear();
        @(posedge user_clk); #1;
    endtask

    task automatic test_reset();
        s_axis_tvalid = 1'b1; s_axis_tdata = mk(0);
        repeat (3) @(posedge user_clk);
        @(negedge user_clk);
        total++;
        if ({s_axis_tready, synced, word_cnt, pkt_cnt, err_cnt, first_err_word, err_flags} !== '0) begin
            bad++;
            $display("FAIL reset_state got tready=%b synced=%b w=%0d p=%0d e=%0d f=%0d fl=%b want all 0",
                     s_axis_tready, synced, word_cnt, pkt_cnt, err_cnt, first_err_word, err_flags);
        end
        @(posedge user_clk); #1;
        dma_rstn = 1'b1;
        repeat (5) begin @(posedge user_clk); #1; end
        total++;
        if ({s_axis_tready, synced, word_cnt} !== '0) begin
            bad++;
            $display("FAIL reset_idle got tready=%b synced=%b w=%0d want 0 0 0", s_axis_tready, synced, word_cnt);
        end
        s_axis_tvalid = 1'b0;
    endtask

    task automatic test_clean();
        restart();
        for (int i = 0; i < 4096; i++) send_beat(mk(32'(i)), is_last(32'(i)), 8'hFF);
        idle(2);
        total++;
        if ({word_cnt, pkt_cnt, err_cnt, err_flags} !== {32'd4096, 32'd2, 16'd0, 4'd0}) begin
            bad++;
            $display("FAIL clean_stats got w=%0d p=%0d e=%0d fl=%b want 4096 2 0 0000",
                     word_cnt, pkt_cnt, err_cnt, err_flags);
        end
        total++;
        if (synced !== 1'b1) begin bad++; $display("FAIL clean_synced got %b want 1", synced); end
    endtask

    task automatic test_corrupt();
        restart();
        for (int i = 0; i < 4096; i++) send_beat(i == 100 ? mk(32'h0BAD) : mk(32'(i)), is_last(32'(i)), 8'hFF);
        idle(2);
        total++;
        if ({err_cnt, first_err_word, err_flags, word_cnt} !== {16'd2, 32'd100, 4'b0001, 32'd4096}) begin
            bad++;
            $display("FAIL corrupt_stats got e=%0d f=%0d fl=%b w=%0d want 2 100 0001 4096",
                     err_cnt, first_err_word, err_flags, word_cnt);
        end
        total++;
        if ({err_cnt, first_err_word, err_flags} !== {m_errs, m_first, m_flags}) begin
            bad++;
            $display("FAIL corrupt_model got e=%0d f=%0d fl=%b want %0d %0d %b",
                     err_cnt, first_err_word, err_flags, m_errs, m_first, m_flags);
        end
    endtask

    task automatic test_framing();
        restart();
        for (int i = 0; i < 4096; i++)
            send_beat(mk(32'(i)), (i == 3000) || (is_last(32'(i)) && i != 2047), 8'hFF);
        idle(2);
        total++;
        if ({err_flags, err_cnt, first_err_word, pkt_cnt} !== {4'b0110, 16'd2, 32'd2047, 32'd2}) begin
            bad++;
            $display("FAIL framing_stats got fl=%b e=%0d f=%0d p=%0d want 0110 2 2047 2",
                     err_flags, err_cnt, first_err_word, pkt_cnt);
        end
    endtask

    task automatic test_throttle();
        throttle_ena = 1'b1;
        restart();
        stall_cyc = 0; run_cyc = 0;
        for (int i = 0; i < 10000; i++) send_beat(mk(32'(i)), is_last(32'(i)), 8'hFF);
        idle(2);
        total++;
        if ({word_cnt, pkt_cnt, err_cnt, err_flags} !== {32'd10000, 32'd4, 16'd0, 4'd0}) begin
            bad++;
            $display("FAIL throttle_stats got w=%0d p=%0d e=%0d fl=%b want 10000 4 0 0000",
                     word_cnt, pkt_cnt, err_cnt, err_flags);
        end
        total++;
        if (stall_cyc * 100 < run_cyc * 20 || stall_cyc * 100 > run_cyc * 30) begin
            bad++;
            $display("FAIL throttle_ratio got %0d stalls of %0d cycles want 20-30 percent", stall_cyc, run_cyc);
        end
        throttle_ena = 1'b0;
    endtask

    task automatic test_disable();
        restart();
        for (int i = 0; i < 500; i++) send_beat(mk(32'(i)), is_last(32'(i)), 8'hFF);
        s_axis_tvalid = 1'b0; chk_ena = 1'b0;
        @(negedge user_clk);
        total++;
        if (s_axis_tready !== 1'b1) begin bad++; $display("FAIL disable_pre got tready=%b want 1", s_axis_tready); end
        @(posedge user_clk); #1;
        total++;
        if ({s_axis_tready, synced} !== 2'b00) begin
            bad++;
            $display("FAIL disable_idle got tready=%b synced=%b want 0 0", s_axis_tready, synced);
        end
        repeat (3) begin @(posedge user_clk); #1; end
        total++;
        if ({word_cnt, err_cnt} !== {32'd500, 16'd0}) begin
            bad++;
            $display("FAIL disable_hold got w=%0d e=%0d want 500 0", word_cnt, err_cnt);
        end
        chk_ena = 1'b1;
        model_clear();
        @(posedge user_clk); #1;
        total++;
        if ({word_cnt, pkt_cnt, synced} !== '0) begin
            bad++;
            $display("FAIL reenable_clear got w=%0d p=%0d synced=%b want 0 0 0", word_cnt, pkt_cnt, synced);
        end
        send_beat(mk(32'h1234_5678), is_last(32'h1234_5678), 8'hFF);
        total++;
        if (synced !== 1'b1) begin bad++; $display("FAIL reenable_synced got %b want 1", synced); end
        for (int i = 1; i < 3000; i++)
            send_beat(mk(32'h1234_5678 + 32'(i)), is_last(32'h1234_5678 + 32'(i)), 8'hFF);
        idle(2);
        total++;
        if ({word_cnt, pkt_cnt, err_cnt, err_flags} !== {m_words, m_pkts, 16'd0, 4'd0}) begin
            bad++;
            $display("FAIL reenable_stats got w=%0d p=%0d e=%0d fl=%b want %0d %0d 0 0000",
                     word_cnt, pkt_cnt, err_cnt, err_flags, m_words, m_pkts);
        end
    endtask

    task automatic test_random();
        logic [31:0] c;
        logic [63:0] d;
        logic        l;
        logic [7:0]  k;
        throttle_ena = 1'($urandom_range(0, 1));
        restart();
        c = 32'hFFFF_FF00;
        for (int i = 0; i < 1500; i++) begin
            d = mk(c); l = is_last(c); k = 8'hFF;
            case ($urandom_range(0, 39))
                0: d[$urandom_range(0, 63)] ^= 1'b1;
                1: l = !l;
                2: k[$urandom_range(0, 7)] = 1'b0;
                3: begin c = c + $urandom_range(2, 5000); d = mk(c); l = is_last(c); end
                default: ;
            endcase
            send_beat(d, l, k);
            c = c + 1;
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(2);
        total++;
        if ({word_cnt, pkt_cnt, err_cnt, err_flags} !== {m_words, m_pkts, m_errs, m_flags}) begin
            bad++;
            $display("FAIL random_stats got w=%0d p=%0d e=%0d fl=%b want %0d %0d %0d %b",
                     word_cnt, pkt_cnt, err_cnt, err_flags, m_words, m_pkts, m_errs, m_flags);
        end
        total++;
        if (first_err_word !== m_first) begin
            bad++;
            $display("FAIL random_first got %0d want %0d", first_err_word, m_first);
        end
        throttle_ena = 1'b0;
    endtask

    task automatic test_async_reset();
        restart();
        for (int i = 0; i < 50; i++) send_beat(mk(32'(i)), 1'b0, 8'hFF);
        #2 dma_rstn = 1'b0;
        #1;
        total++;
        if ({s_axis_tready, synced, word_cnt, err_cnt} !== '0) begin
            bad++;
            $display("FAIL async_reset got tready=%b synced=%b w=%0d e=%0d want 0 0 0 0",
                     s_axis_tready, synced, word_cnt, err_cnt);
        end
        @(posedge user_clk); #1;
        dma_rstn = 1'b1;
        s_axis_tvalid = 1'b0;
        restart();
        for (int i = 7; i < 40; i++) send_beat(mk(32'(i)), 1'b0, 8'hFF);
        idle(2);
        total++;
        if ({word_cnt, err_cnt} !== {32'd33, 16'd0}) begin
            bad++;
            $display("FAIL post_reset_stats got w=%0d e=%0d want 33 0", word_cnt, err_cnt);
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_clean();
        test_corrupt();
        test_framing();
        test_throttle();
        test_disable();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
